// File: rtl/avmm_mem_responder.sv
//==============================================================================
// Module      : avmm_mem_responder
// Description : Avalon-MM style memory responder. One write and one read
//               channel share a single-port synchronous RAM. A three-state FSM
//               serialises requests, adds a configurable completion latency
//               per direction and flags misaligned / out-of-range addresses.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module avmm_mem_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int WR_LATENCY = 1,
    parameter int RD_LATENCY = 2
) (
    input  logic        ctrl_clk,
    input  logic        reset_n,
    input  logic [31:0] write_addr,
    input  logic [31:0] iData,
    input  logic        write,
    output logic        write_waitrequest,
    input  logic [31:0] read_addr,
    input  logic        read,
    output logic [31:0] oData,
    output logic        read_waitrequest,
    output logic        addr_err
);

    localparam logic [3:0] c_WR_LAT = 4'(WR_LATENCY);
    localparam logic [3:0] c_RD_LAT = 4'(RD_LATENCY);
    localparam int         c_WORDS  = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_BUSY = 2'd1,
        ST_RD_BUSY = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [3:0]              r_cnt, w_cnt_nxt;
    logic                    r_last_rd, w_last_rd_nxt;
    logic                    r_wr_wait, w_wr_wait_nxt;
    logic                    r_rd_wait, w_rd_wait_nxt;
    logic                    r_addr_err;
    logic [31:0]             r_rdata;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [31:0]             r_wdata;
    logic [31:0]             r_mem [0:c_WORDS-1];

    logic                    w_accept_wr, w_accept_rd;
    logic                    w_ram_we, w_rd_fire;
    logic [31:0]             w_in_addr;
    logic                    w_err_set;
    logic [DEPTH_LOG2-1:0]   w_rd_idx;

    // Address checked at acceptance is whichever channel wins arbitration.
    assign w_in_addr = w_accept_wr ? write_addr : read_addr;
    assign w_err_set = (w_accept_wr || w_accept_rd) &&
                       ((w_in_addr[1:0] != 2'b00) ||
                        ((w_in_addr >> (DEPTH_LOG2 + 2)) != 32'd0));

    // A single-cycle read latency fetches during the accept cycle, so the
    // incoming address is used directly; otherwise the latched index is used.
    assign w_rd_idx = (r_state == ST_IDLE) ? read_addr[DEPTH_LOG2+1:2] : r_idx;

    // Next-state, arbitration and completion timing.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_last_rd_nxt = r_last_rd;
        w_wr_wait_nxt = 1'b1;
        w_rd_wait_nxt = 1'b1;
        w_accept_wr   = 1'b0;
        w_accept_rd   = 1'b0;
        w_ram_we      = 1'b0;
        w_rd_fire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // last_grant only moves on a tie, so ties alternate.
                if (write && (!read || r_last_rd)) begin
                    w_accept_wr   = 1'b1;
                    w_state_nxt   = ST_WR_BUSY;
                    w_cnt_nxt     = c_WR_LAT - 4'd1;
                    w_wr_wait_nxt = (c_WR_LAT == 4'd1) ? 1'b0 : 1'b1;
                    if (read) w_last_rd_nxt = 1'b0;
                end else if (read) begin
                    w_accept_rd   = 1'b1;
                    w_state_nxt   = ST_RD_BUSY;
                    w_cnt_nxt     = c_RD_LAT - 4'd1;
                    w_rd_wait_nxt = (c_RD_LAT == 4'd1) ? 1'b0 : 1'b1;
                    w_rd_fire     = (c_RD_LAT == 4'd1);
                    if (write) w_last_rd_nxt = 1'b1;
                end
            end
            ST_WR_BUSY: begin
                if (!write) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (!r_wr_wait) begin
                    w_ram_we    = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) w_wr_wait_nxt = 1'b0;
                end
            end
            ST_RD_BUSY: begin
                if (!read || !r_rd_wait) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_rd_wait_nxt = 1'b0;
                        w_rd_fire     = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Control state, registered waitrequests, read data and sticky error.
    always_ff @(posedge ctrl_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_last_rd  <= 1'b1;
            r_wr_wait  <= 1'b1;
            r_rd_wait  <= 1'b1;
            r_addr_err <= 1'b0;
            r_rdata    <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_last_rd <= w_last_rd_nxt;
            r_wr_wait <= w_wr_wait_nxt;
            r_rd_wait <= w_rd_wait_nxt;
            if (w_err_set) r_addr_err <= 1'b1;
            if (w_rd_fire) r_rdata <= r_mem[w_rd_idx];
        end
    end

    // Request capture; datapath only, so no reset is needed.
    always_ff @(posedge ctrl_clk) begin
        if (w_accept_wr) begin
            r_idx   <= write_addr[DEPTH_LOG2+1:2];
            r_wdata <= iData;
        end else if (w_accept_rd) begin
            r_idx   <= read_addr[DEPTH_LOG2+1:2];
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge ctrl_clk) begin
        if (w_ram_we) r_mem[r_idx] <= r_wdata;
    end

    assign write_waitrequest = r_wr_wait;
    assign read_waitrequest  = r_rd_wait;
    assign oData             = r_rdata;
    assign addr_err          = r_addr_err;

endmodule

`default_nettype wire

// File: tb/tb_avmm_mem_responder.sv
//==============================================================================
// Module      : tb_avmm_mem_responder
// Description : Directed self-checking bench for avmm_mem_responder.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_avmm_mem_responder;

    localparam int c_WR_LAT = 1;
    localparam int c_RD_LAT = 2;

    logic        ctrl_clk = 1'b0;
    logic        reset_n  = 1'b0;
    logic [31:0] write_addr = '0;
    logic [31:0] iData = '0;
    logic        write = 1'b0;
    logic        write_waitrequest;
    logic [31:0] read_addr = '0;
    logic        read = 1'b0;
    logic [31:0] oData;
    logic        read_waitrequest;
    logic        addr_err;

    int checks   = 0;
    int failures = 0;

    avmm_mem_responder #(
        .DEPTH_LOG2 (12),
        .WR_LATENCY (c_WR_LAT),
        .RD_LATENCY (c_RD_LAT)
    ) dut (
        .ctrl_clk          (ctrl_clk),
        .reset_n           (reset_n),
        .write_addr        (write_addr),
        .iData             (iData),
        .write             (write),
        .write_waitrequest (write_waitrequest),
        .read_addr         (read_addr),
        .read              (read),
        .oData             (oData),
        .read_waitrequest  (read_waitrequest),
        .addr_err          (addr_err)
    );

    always #5 ctrl_clk = ~ctrl_clk;

    // Move to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge ctrl_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Both completion strobes must never be low together.
    always @(negedge ctrl_clk) begin
        if (reset_n) begin
            checks++;
            assert (!((write_waitrequest === 1'b0) && (read_waitrequest === 1'b0)))
            else begin
                failures++;
                $error("FAIL both_wait_low observed=%b%b expected=not 00",
                       write_waitrequest, read_waitrequest);
            end
        end
    end

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d);
        int n;
        write_addr = a;
        iData      = d;
        write      = 1'b1;
        tick();
        n = 1;
        while (write_waitrequest && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_wr_latency"}, 32'(n), 32'(c_WR_LAT));
        chk({tag, "_wr_wait_low"}, {31'd0, write_waitrequest}, 32'd0);
        tick();
        write = 1'b0;
        chk({tag, "_wr_wait_back_high"}, {31'd0, write_waitrequest}, 32'd1);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        int n;
        read_addr = a;
        read      = 1'b1;
        tick();
        n = 1;
        while (read_waitrequest && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_rd_latency"}, 32'(n), 32'(c_RD_LAT));
        chk({tag, "_rd_data"}, oData, exp);
        tick();
        read = 1'b0;
        chk({tag, "_rd_wait_back_high"}, {31'd0, read_waitrequest}, 32'd1);
        chk({tag, "_rd_data_held"}, oData, exp);
    endtask

    initial begin
        // Reset values.
        repeat (3) tick();
        chk("rst_wr_wait", {31'd0, write_waitrequest}, 32'd1);
        chk("rst_rd_wait", {31'd0, read_waitrequest}, 32'd1);
        chk("rst_odata", oData, 32'd0);
        chk("rst_addr_err", {31'd0, addr_err}, 32'd0);

        // First tie, present as reset releases: write wins on the first edge.
        write_addr = 32'h20; iData = 32'h1111_1111; write = 1'b1;
        read_addr  = 32'h20; read  = 1'b1;
        reset_n = 1'b1;
        tick();
        chk("tie1_wr_done", {31'd0, write_waitrequest}, 32'd0);
        chk("tie1_rd_wait", {31'd0, read_waitrequest}, 32'd1);
        tick();
        write = 1'b0;
        chk("tie1_wr_wait_high", {31'd0, write_waitrequest}, 32'd1);
        tick();
        chk("tie1_rd_busy", {31'd0, read_waitrequest}, 32'd1);
        tick();
        chk("tie1_rd_done", {31'd0, read_waitrequest}, 32'd0);
        chk("tie1_rd_data", oData, 32'h1111_1111);
        tick();
        read = 1'b0;
        chk("tie1_rd_data_held", oData, 32'h1111_1111);

        // Second tie: read is granted first and sees the old value.
        write_addr = 32'h20; iData = 32'h2222_2222; write = 1'b1;
        read_addr  = 32'h20; read  = 1'b1;
        tick();
        chk("tie2_rd_busy", {31'd0, read_waitrequest}, 32'd1);
        chk("tie2_wr_pending", {31'd0, write_waitrequest}, 32'd1);
        tick();
        chk("tie2_rd_done", {31'd0, read_waitrequest}, 32'd0);
        chk("tie2_rd_data", oData, 32'h1111_1111);
        chk("tie2_wr_still_wait", {31'd0, write_waitrequest}, 32'd1);
        tick();
        read = 1'b0;
        tick();
        chk("tie2_wr_done", {31'd0, write_waitrequest}, 32'd0);
        tick();
        write = 1'b0;
        do_read("tie2_readback", 32'h20, 32'h2222_2222);

        // Plain write then read.
        do_write("wr10", 32'h10, 32'hDEAD_BEEF);
        do_read("rd10", 32'h10, 32'hDEAD_BEEF);
        chk("no_err_aligned", {31'd0, addr_err}, 32'd0);

        // Aliasing and the sticky error flag.
        do_write("wr4000", 32'h4000, 32'h0000_0001);
        chk("err_out_of_range", {31'd0, addr_err}, 32'd1);
        do_read("rd0_alias", 32'h0, 32'h0000_0001);
        do_write("wr13", 32'h13, 32'hCAFE_F00D);
        do_read("rd10_alias", 32'h10, 32'hCAFE_F00D);
        chk("err_sticky", {31'd0, addr_err}, 32'd1);

        // Abort: read dropped in T+1.
        read_addr = 32'h20; read = 1'b1;
        tick();
        read = 1'b0;
        chk("abort_t1_wait", {31'd0, read_waitrequest}, 32'd1);
        tick();
        chk("abort_t2_wait", {31'd0, read_waitrequest}, 32'd1);
        chk("abort_odata", oData, 32'hCAFE_F00D);
        do_read("after_abort", 32'h20, 32'h2222_2222);

        // Reset in the middle of a read.
        read_addr = 32'h10; read = 1'b1;
        tick();
        reset_n = 1'b0;
        read    = 1'b0;
        #1;
        chk("midrst_rd_wait", {31'd0, read_waitrequest}, 32'd1);
        chk("midrst_odata", oData, 32'd0);
        chk("midrst_err_clr", {31'd0, addr_err}, 32'd0);
        tick();
        tick();
        chk("midrst_rd_wait_hold", {31'd0, read_waitrequest}, 32'd1);
        reset_n = 1'b1;
        tick();
        chk("midrst_odata_after", oData, 32'd0);
        do_read("midrst_readback", 32'h10, 32'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
